// File: rtl/srisc_cpu_core_p.sv
// srisc_cpu_core_p: multi-cycle 16-bit-instruction RISC core with 8 registers, ALU,
// BL/BX/BLX call-return and a halt on undefined opcodes. Memory accesses use a ready
// handshake. Define SRCPU_TIMEOUT_EN to halt with err=1 when an access waits too long.
module srisc_cpu_core_p #(
    parameter int unsigned    DW          = 16,
    parameter int unsigned    AW          = 9,
    parameter logic [AW-1:0]  RESET_PC    = '0,
    parameter int unsigned    MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] out,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          err
);

    localparam logic [2:0] StReset  = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StAddr   = 3'd4;
    localparam logic [2:0] StMem    = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    localparam logic [1:0] CmdNone  = 2'b00;
    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [AW-1:0] dar_q, dar_d;
    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic          n_q, n_d, z_q, z_d, v_q, v_d;
    logic [DW-1:0] out_q, out_d;
    logic          err_q, err_d;

    // Instruction fields
    logic [2:0] op, rn, rd, rm, cond;
    logic [1:0] sub, sh;
    assign op   = ir_q[15:13];
    assign sub  = ir_q[12:11];
    assign rn   = ir_q[10:8];
    assign cond = ir_q[10:8];
    assign rd   = ir_q[7:5];
    assign sh   = ir_q[4:3];
    assign rm   = ir_q[2:0];

    logic [DW-1:0] rn_val, rd_val, rm_val, shb, diff, addr_sum, sximm5, sximm8;
    logic [AW-1:0] sximm8_a;
    logic          diff_v, taken;

    // Operand read, shifter, immediates and branch condition
    always_comb begin
        rn_val   = rf_q[rn];
        rd_val   = rf_q[rd];
        rm_val   = rf_q[rm];
        sximm5   = DW'($signed(ir_q[4:0]));
        sximm8   = DW'($signed(ir_q[7:0]));
        sximm8_a = AW'($signed(ir_q[7:0]));
        case (sh)
            2'b01:   shb = {rm_val[DW-2:0], 1'b0};
            2'b10:   shb = {1'b0, rm_val[DW-1:1]};
            2'b11:   shb = {rm_val[DW-1], rm_val[DW-1:1]};
            default: shb = rm_val;
        endcase
        diff     = rn_val - shb;
        diff_v   = (rn_val[DW-1] != shb[DW-1]) && (diff[DW-1] != rn_val[DW-1]);
        addr_sum = rn_val + sximm5;
        case (cond)
            3'd0:    taken = 1'b1;
            3'd1:    taken = z_q;
            3'd2:    taken = !z_q;
            3'd3:    taken = (n_q != v_q);
            3'd4:    taken = (n_q != v_q) || z_q;
            default: taken = 1'b0;
        endcase
    end

`ifdef SRCPU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1) + 1;
    logic [TW-1:0] wait_q, wait_d;
`else
    logic unused_timeout;
    assign unused_timeout = (MEM_TIMEOUT != 0);
`endif

    // Next-state logic for the control FSM and the datapath registers
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dar_d   = dar_q;
        rf_d    = rf_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + AW'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StFetch;
                case (op)
                    3'b110: begin
                        if (sub == 2'b10 || sub == 2'b00) begin
                            state_d = StExec;
                        end else begin
                            state_d = StHalt;
                            err_d   = 1'b1;
                        end
                    end
                    3'b101: state_d = StExec;
                    3'b011, 3'b100: begin
                        if (sub == 2'b00) begin
                            state_d = StAddr;
                        end else begin
                            state_d = StHalt;
                            err_d   = 1'b1;
                        end
                    end
                    3'b001: begin
                        if (sub == 2'b00 && cond <= 3'd4) begin
                            if (taken) pc_d = pc_q + sximm8_a;
                        end else begin
                            state_d = StHalt;
                            err_d   = 1'b1;
                        end
                    end
                    3'b010: begin
                        // Rd is sampled before R7 is written, so BLX R7 uses the old R7
                        case (sub)
                            2'b11: begin
                                rf_d[7] = DW'(pc_q);
                                pc_d    = pc_q + sximm8_a;
                            end
                            2'b00: pc_d = rd_val[AW-1:0];
                            2'b10: begin
                                rf_d[7] = DW'(pc_q);
                                pc_d    = rd_val[AW-1:0];
                            end
                            default: begin
                                state_d = StHalt;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                    3'b111: state_d = StHalt;
                    default: begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                endcase
            end
            StExec: begin
                state_d = StFetch;
                if (op == 3'b110) begin
                    if (sub == 2'b10) begin
                        rf_d[rn] = sximm8;
                        out_d    = sximm8;
                    end else begin
                        rf_d[rd] = shb;
                        out_d    = shb;
                    end
                end else begin
                    case (sub)
                        2'b00: begin
                            rf_d[rd] = rn_val + shb;
                            out_d    = rn_val + shb;
                        end
                        2'b01: begin
                            out_d = diff;
                            n_d   = diff[DW-1];
                            z_d   = (diff == '0);
                            v_d   = diff_v;
                        end
                        2'b10: begin
                            rf_d[rd] = rn_val & shb;
                            out_d    = rn_val & shb;
                        end
                        default: begin
                            rf_d[rd] = ~shb;
                            out_d    = ~shb;
                        end
                    endcase
                end
            end
            StAddr: begin
                dar_d   = addr_sum[AW-1:0];
                out_d   = addr_sum;
                state_d = StMem;
            end
            StMem: begin
                if (mem_ready) begin
                    if (op == 3'b011) rf_d[rd] = mem_rdata;
                    state_d = StFetch;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
`ifdef SRCPU_TIMEOUT_EN
        wait_d = '0;
        if ((state_q == StFetch || state_q == StMem) && !mem_ready) begin
            if (wait_q >= TW'(MEM_TIMEOUT - 1)) begin
                state_d = StHalt;
                err_d   = 1'b1;
            end else begin
                wait_d = wait_q + TW'(1);
            end
        end
`endif
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            dar_q   <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
`ifdef SRCPU_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dar_q   <= dar_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            out_q   <= out_d;
            err_q   <= err_d;
`ifdef SRCPU_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Memory interface and status outputs decoded from state
    always_comb begin
        mem_cmd   = CmdNone;
        mem_addr  = pc_q;
        mem_wdata = '0;
        if (state_q == StFetch) begin
            mem_cmd = CmdRead;
        end else if (state_q == StMem) begin
            mem_addr = dar_q;
            if (op == 3'b011) begin
                mem_cmd = CmdRead;
            end else begin
                mem_cmd   = CmdWrite;
                mem_wdata = rd_val;
            end
        end
        out    = out_q;
        pc     = pc_q;
        halted = (state_q == StHalt);
        err    = err_q;
    end

endmodule
